// File: rtl/vx_rop_csr_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : rop_types
//  Description : Shared types for the ROP CSR bank. Holds the ROP CSR set
//                structure, the CSR field index map, the commit FSM state
//                encoding and the field-update helper used by every context.
//  Revision    : 1.0 - initial release
// ============================================================================
package rop_types;

    // Field widths. Address/pitch fields are carried at full 32 bits in the
    // structure; narrower ADDR_WIDTH configurations zero the unused MSBs.
    localparam int ROP_ADDR_BITS       = 32;
    localparam int ROP_DEPTH_FUNC_BITS = 3;
    localparam int ROP_STENCIL_OP_BITS = 3;
    localparam int ROP_BLEND_FUNC_BITS = 4;
    localparam int ROP_BLEND_MODE_BITS = 3;
    localparam int ROP_LOGIC_OP_BITS   = 4;
    localparam int ROP_CSR_ADDR_BITS   = 5;

    // CSR field index map
    localparam logic [4:0] ROP_CSR_ZBUF_ADDR          = 5'd0;
    localparam logic [4:0] ROP_CSR_ZBUF_PITCH         = 5'd1;
    localparam logic [4:0] ROP_CSR_CBUF_ADDR          = 5'd2;
    localparam logic [4:0] ROP_CSR_CBUF_PITCH         = 5'd3;
    localparam logic [4:0] ROP_CSR_ZFUNC              = 5'd4;
    localparam logic [4:0] ROP_CSR_SFUNC              = 5'd5;
    localparam logic [4:0] ROP_CSR_ZFAIL              = 5'd6;
    localparam logic [4:0] ROP_CSR_ZPASS              = 5'd7;
    localparam logic [4:0] ROP_CSR_SFAIL              = 5'd8;
    localparam logic [4:0] ROP_CSR_BLEND_FUNC_SRC_RGB = 5'd9;
    localparam logic [4:0] ROP_CSR_BLEND_FUNC_DST_RGB = 5'd10;
    localparam logic [4:0] ROP_CSR_BLEND_FUNC_SRC_A   = 5'd11;
    localparam logic [4:0] ROP_CSR_BLEND_FUNC_DST_A   = 5'd12;
    localparam logic [4:0] ROP_CSR_BLEND_MODE_RGB     = 5'd13;
    localparam logic [4:0] ROP_CSR_BLEND_MODE_A       = 5'd14;
    localparam logic [4:0] ROP_CSR_BLEND_CONST        = 5'd15;
    localparam logic [4:0] ROP_CSR_LOGIC_OP           = 5'd16;

    typedef struct packed {
        logic [ROP_ADDR_BITS-1:0]       zbuf_addr;
        logic [ROP_ADDR_BITS-1:0]       zbuf_pitch;
        logic [ROP_ADDR_BITS-1:0]       cbuf_addr;
        logic [ROP_ADDR_BITS-1:0]       cbuf_pitch;
        logic [ROP_DEPTH_FUNC_BITS-1:0] zfunc;
        logic [ROP_DEPTH_FUNC_BITS-1:0] sfunc;
        logic [ROP_STENCIL_OP_BITS-1:0] zfail;
        logic [ROP_STENCIL_OP_BITS-1:0] zpass;
        logic [ROP_STENCIL_OP_BITS-1:0] sfail;
        logic [ROP_BLEND_FUNC_BITS-1:0] blend_func_src_rgb;
        logic [ROP_BLEND_FUNC_BITS-1:0] blend_func_dst_rgb;
        logic [ROP_BLEND_FUNC_BITS-1:0] blend_func_src_a;
        logic [ROP_BLEND_FUNC_BITS-1:0] blend_func_dst_a;
        logic [ROP_BLEND_MODE_BITS-1:0] blend_mode_rgb;
        logic [ROP_BLEND_MODE_BITS-1:0] blend_mode_a;
        logic [31:0]                    blend_const;
        logic [ROP_LOGIC_OP_BITS-1:0]   logic_op;
    } rop_csrs_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        COPY  = 2'd2
    } commit_state_t;

    // Returns cur with one field replaced. Narrow fields keep the low-order
    // data bits; indices outside the map leave the set untouched.
    function automatic rop_csrs_t rop_csr_write(
        input rop_csrs_t   cur,
        input logic [4:0]  addr,
        input logic [31:0] data,
        input logic [31:0] addr_mask
    );
        rop_csrs_t nxt;
        nxt = cur;
        case (addr)
            ROP_CSR_ZBUF_ADDR:          nxt.zbuf_addr          = data & addr_mask;
            ROP_CSR_ZBUF_PITCH:         nxt.zbuf_pitch         = data & addr_mask;
            ROP_CSR_CBUF_ADDR:          nxt.cbuf_addr          = data & addr_mask;
            ROP_CSR_CBUF_PITCH:         nxt.cbuf_pitch         = data & addr_mask;
            ROP_CSR_ZFUNC:              nxt.zfunc              = data[ROP_DEPTH_FUNC_BITS-1:0];
            ROP_CSR_SFUNC:              nxt.sfunc              = data[ROP_DEPTH_FUNC_BITS-1:0];
            ROP_CSR_ZFAIL:              nxt.zfail              = data[ROP_STENCIL_OP_BITS-1:0];
            ROP_CSR_ZPASS:              nxt.zpass              = data[ROP_STENCIL_OP_BITS-1:0];
            ROP_CSR_SFAIL:              nxt.sfail              = data[ROP_STENCIL_OP_BITS-1:0];
            ROP_CSR_BLEND_FUNC_SRC_RGB: nxt.blend_func_src_rgb = data[ROP_BLEND_FUNC_BITS-1:0];
            ROP_CSR_BLEND_FUNC_DST_RGB: nxt.blend_func_dst_rgb = data[ROP_BLEND_FUNC_BITS-1:0];
            ROP_CSR_BLEND_FUNC_SRC_A:   nxt.blend_func_src_a   = data[ROP_BLEND_FUNC_BITS-1:0];
            ROP_CSR_BLEND_FUNC_DST_A:   nxt.blend_func_dst_a   = data[ROP_BLEND_FUNC_BITS-1:0];
            ROP_CSR_BLEND_MODE_RGB:     nxt.blend_mode_rgb     = data[ROP_BLEND_MODE_BITS-1:0];
            ROP_CSR_BLEND_MODE_A:       nxt.blend_mode_a       = data[ROP_BLEND_MODE_BITS-1:0];
            ROP_CSR_BLEND_CONST:        nxt.blend_const        = data;
            ROP_CSR_LOGIC_OP:           nxt.logic_op           = data[ROP_LOGIC_OP_BITS-1:0];
            default:                    nxt = cur;
        endcase
        return nxt;
    endfunction

endpackage : rop_types
`default_nettype wire

// File: rtl/vx_rop_csr_bank_ctx.sv
`default_nettype none
// ============================================================================
//  Module      : vx_rop_csr_ctx
//  Description : One ROP state context: shadow CSR set (software-written),
//                active CSR set (seen by fragments) and the count of
//                fragments currently in flight against the active set.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, reset_n   clock, synchronous active-low reset
//    i_wr_en        write one shadow field (i_wr_addr / i_wr_data)
//    i_commit       copy shadow -> active at this edge
//    i_issue        one fragment issued against this context
//    i_retire       one fragment retired from this context
//    o_active       active CSR set
//    o_inflight     in-flight fragment count
// ============================================================================
module vx_rop_csr_ctx
    import rop_types::*;
#(
    parameter int ADDR_WIDTH    = 32,
    parameter int INFLIGHT_BITS = 6
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     i_wr_en,
    input  logic [4:0]               i_wr_addr,
    input  logic [31:0]              i_wr_data,
    input  logic                     i_commit,
    input  logic                     i_issue,
    input  logic                     i_retire,
    output rop_csrs_t                o_active,
    output logic [INFLIGHT_BITS-1:0] o_inflight
);

    // Keeps only the ADDR_WIDTH low bits of address and pitch fields.
    localparam logic [31:0] c_ADDR_MASK = (ADDR_WIDTH >= 32) ? 32'hFFFF_FFFF
                                        : 32'((64'd1 << ADDR_WIDTH) - 64'd1);
    localparam logic [INFLIGHT_BITS-1:0] c_ONE = INFLIGHT_BITS'(1);

    rop_csrs_t                r_shadow;
    rop_csrs_t                r_active;
    logic [INFLIGHT_BITS-1:0] r_inflight;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_shadow   <= '0;
            r_active   <= '0;
            r_inflight <= '0;
        end else begin
            if (i_wr_en) begin
                r_shadow <= rop_csr_write(r_shadow, i_wr_addr, i_wr_data, c_ADDR_MASK);
            end
            if (i_commit) begin
                r_active <= r_shadow;
            end
            // Issue+retire together cancel. Issue is never presented on a
            // full counter (upstream ready gating); retire saturates at 0.
            if (i_issue && !i_retire) begin
                r_inflight <= r_inflight + c_ONE;
            end else if (i_retire && !i_issue && (r_inflight != '0)) begin
                r_inflight <= r_inflight - c_ONE;
            end
        end
    end

    assign o_active   = r_active;
    assign o_inflight = r_inflight;

endmodule : vx_rop_csr_ctx
`default_nettype wire

// File: rtl/vx_rop_csr_bank.sv
`default_nettype none
// ============================================================================
//  Module      : vx_rop_csr_bank
//  Description : Multi-context ROP CSR bank. Software writes shadow CSRs per
//                context; a commit waits for that context's in-flight
//                fragments to drain, then copies shadow to active. Each
//                issued fragment gets a registered copy of its context's
//                active state one cycle later.
//  Revision    : 1.0 - initial release
//
//  Ports
//    clk, reset_n                     clock, synchronous active-low reset
//    csr_wr_valid/ready/ctx/addr/data CSR shadow write
//    commit_valid/ready/ctx, commit_done  commit request, completion pulse
//    issue_valid/ready/ctx            fragment issue
//    retire_valid/ctx                 fragment retire (no backpressure)
//    out_valid/out_csrs               active state for the issued fragment
// ============================================================================
module vx_rop_csr_bank
    import rop_types::*;
#(
    parameter int NUM_CTX       = 4,
    parameter int ADDR_WIDTH    = 32,
    parameter int INFLIGHT_BITS = 6,
    localparam int CTX_W        = $clog2(NUM_CTX)
) (
    input  logic             clk,
    input  logic             reset_n,

    input  logic             csr_wr_valid,
    output logic             csr_wr_ready,
    input  logic [CTX_W-1:0] csr_wr_ctx,
    input  logic [4:0]       csr_wr_addr,
    input  logic [31:0]      csr_wr_data,

    input  logic             commit_valid,
    output logic             commit_ready,
    input  logic [CTX_W-1:0] commit_ctx,
    output logic             commit_done,

    input  logic             issue_valid,
    output logic             issue_ready,
    input  logic [CTX_W-1:0] issue_ctx,

    input  logic             retire_valid,
    input  logic [CTX_W-1:0] retire_ctx,

    output logic             out_valid,
    output rop_csrs_t        out_csrs
);

    commit_state_t            r_state;
    commit_state_t            w_state_nxt;
    logic [CTX_W-1:0]         r_cctx;
    logic [CTX_W-1:0]         w_cctx_nxt;

    rop_csrs_t                w_active   [NUM_CTX];
    logic [INFLIGHT_BITS-1:0] w_inflight [NUM_CTX];

    logic                     w_wr_fire;
    logic                     w_issue_fire;
    logic                     w_copy;

    logic                     r_out_valid;
    rop_csrs_t                r_out_csrs;

    // ------------------------------------------------------------------
    // Commit FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cctx  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cctx  <= w_cctx_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cctx_nxt   = r_cctx;
        commit_ready = 1'b0;
        commit_done  = 1'b0;
        csr_wr_ready = 1'b1;
        w_copy       = 1'b0;
        case (r_state)
            IDLE: begin
                commit_ready = 1'b1;
                if (commit_valid) begin
                    w_state_nxt = DRAIN;
                    w_cctx_nxt  = commit_ctx;
                end
            end
            DRAIN: begin
                // The committing context accepts no new issues, so its count
                // only falls; once zero it stays zero until COPY completes.
                if (w_inflight[r_cctx] == '0) begin
                    w_state_nxt = COPY;
                end
            end
            COPY: begin
                // Writes are held off so the shadow copied is exactly the one
                // present when the copy fires.
                csr_wr_ready = 1'b0;
                commit_done  = 1'b1;
                w_copy       = 1'b1;
                w_state_nxt  = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign issue_ready  = !(&w_inflight[issue_ctx])
                       && !((r_state != IDLE) && (issue_ctx == r_cctx));
    assign w_wr_fire    = csr_wr_valid && csr_wr_ready;
    assign w_issue_fire = issue_valid && issue_ready;

    // ------------------------------------------------------------------
    // Per-context state
    // ------------------------------------------------------------------
    for (genvar g = 0; g < NUM_CTX; g++) begin : g_ctx
        vx_rop_csr_ctx #(
            .ADDR_WIDTH    (ADDR_WIDTH),
            .INFLIGHT_BITS (INFLIGHT_BITS)
        ) u_ctx (
            .clk        (clk),
            .reset_n    (reset_n),
            .i_wr_en    (w_wr_fire && (csr_wr_ctx == CTX_W'(g))),
            .i_wr_addr  (csr_wr_addr),
            .i_wr_data  (csr_wr_data),
            .i_commit   (w_copy && (r_cctx == CTX_W'(g))),
            .i_issue    (w_issue_fire && (issue_ctx == CTX_W'(g))),
            .i_retire   (retire_valid && (retire_ctx == CTX_W'(g))),
            .o_active   (w_active[g]),
            .o_inflight (w_inflight[g])
        );
    end

    // ------------------------------------------------------------------
    // Fragment state output
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_out_csrs  <= '0;
        end else begin
            r_out_valid <= w_issue_fire;
            if (w_issue_fire) begin
                r_out_csrs <= w_active[issue_ctx];
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_csrs  = r_out_csrs;

endmodule : vx_rop_csr_bank
`default_nettype wire

// File: tb/tb_vx_rop_csr_bank.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_vx_rop_csr_bank
//  Description : Self-checking bench for vx_rop_csr_bank. Issued fragments
//                push their expected CSR set into a queue; a monitor pops
//                and compares whenever out_valid is seen.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vx_rop_csr_bank;
    import rop_types::*;

    localparam int NUM_CTX = 4;
    localparam int CTX_W   = 2;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             csr_wr_valid, csr_wr_ready;
    logic [CTX_W-1:0] csr_wr_ctx;
    logic [4:0]       csr_wr_addr;
    logic [31:0]      csr_wr_data;
    logic             commit_valid, commit_ready, commit_done;
    logic [CTX_W-1:0] commit_ctx;
    logic             issue_valid, issue_ready;
    logic [CTX_W-1:0] issue_ctx;
    logic             retire_valid;
    logic [CTX_W-1:0] retire_ctx;
    logic             out_valid;
    rop_csrs_t        out_csrs;

    always #5 clk = ~clk;

    vx_rop_csr_bank #(
        .NUM_CTX       (NUM_CTX),
        .ADDR_WIDTH    (32),
        .INFLIGHT_BITS (6)
    ) u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .csr_wr_valid (csr_wr_valid),
        .csr_wr_ready (csr_wr_ready),
        .csr_wr_ctx   (csr_wr_ctx),
        .csr_wr_addr  (csr_wr_addr),
        .csr_wr_data  (csr_wr_data),
        .commit_valid (commit_valid),
        .commit_ready (commit_ready),
        .commit_ctx   (commit_ctx),
        .commit_done  (commit_done),
        .issue_valid  (issue_valid),
        .issue_ready  (issue_ready),
        .issue_ctx    (issue_ctx),
        .retire_valid (retire_valid),
        .retire_ctx   (retire_ctx),
        .out_valid    (out_valid),
        .out_csrs     (out_csrs)
    );

    int        n_total = 0;
    int        n_bad   = 0;
    rop_csrs_t exp_q [$];
    rop_csrs_t m_shadow [NUM_CTX];
    rop_csrs_t m_active [NUM_CTX];

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Reference field update, written from the field map.
    function automatic rop_csrs_t m_wr(input rop_csrs_t c, input int a, input logic [31:0] d);
        rop_csrs_t r;
        r = c;
        case (a)
            0:  r.zbuf_addr          = d;
            1:  r.zbuf_pitch         = d;
            2:  r.cbuf_addr          = d;
            3:  r.cbuf_pitch         = d;
            4:  r.zfunc              = d[2:0];
            5:  r.sfunc              = d[2:0];
            6:  r.zfail              = d[2:0];
            7:  r.zpass              = d[2:0];
            8:  r.sfail              = d[2:0];
            9:  r.blend_func_src_rgb = d[3:0];
            10: r.blend_func_dst_rgb = d[3:0];
            11: r.blend_func_src_a   = d[3:0];
            12: r.blend_func_dst_a   = d[3:0];
            13: r.blend_mode_rgb     = d[2:0];
            14: r.blend_mode_a       = d[2:0];
            15: r.blend_const        = d;
            16: r.logic_op           = d[3:0];
            default: r = c;
        endcase
        return r;
    endfunction

    // Scoreboard monitor
    always @(negedge clk) begin : mon
        rop_csrs_t e;
        if (reset_n === 1'b1 && out_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("out_unexpected", out_valid, 1'b0);
            end else begin
                e = exp_q.pop_front();
                chk("out_csrs", out_csrs, e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input int ctx, input int a, input logic [31:0] d);
        csr_wr_valid = 1'b1;
        csr_wr_ctx   = CTX_W'(ctx);
        csr_wr_addr  = 5'(a);
        csr_wr_data  = d;
        #1;
        chk("wr_ready", csr_wr_ready, 1'b1);
        tick();
        csr_wr_valid = 1'b0;
        m_shadow[ctx] = m_wr(m_shadow[ctx], a, d);
    endtask

    task automatic do_issue(input int ctx);
        issue_valid = 1'b1;
        issue_ctx   = CTX_W'(ctx);
        #1;
        chk("issue_ready", issue_ready, 1'b1);
        exp_q.push_back(m_active[ctx]);
        tick();
        issue_valid = 1'b0;
        chk("out_valid_lat", out_valid, 1'b1);
    endtask

    task automatic do_retire(input int ctx);
        retire_valid = 1'b1;
        retire_ctx   = CTX_W'(ctx);
        tick();
        retire_valid = 1'b0;
    endtask

    task automatic start_commit(input int ctx);
        commit_valid = 1'b1;
        commit_ctx   = CTX_W'(ctx);
        #1;
        chk("commit_ready", commit_ready, 1'b1);
        tick();
        commit_valid = 1'b0;
    endtask

    // Waits (bounded) for commit_done; exp_wait is cycles from now.
    task automatic wait_done(input int ctx, input int exp_wait);
        int n;
        n = 0;
        while (commit_done !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        chk("commit_wait", n, exp_wait);
        if (commit_done === 1'b1) begin
            chk("wr_ready_in_copy", csr_wr_ready, 1'b0);
            m_active[ctx] = m_shadow[ctx];
        end
        tick();
        chk("done_one_cycle", commit_done, 1'b0);
        chk("wr_ready_after", csr_wr_ready, 1'b1);
        chk("commit_ready_after", commit_ready, 1'b1);
    endtask

    task automatic do_commit(input int ctx);
        start_commit(ctx);
        chk("done_early", commit_done, 1'b0);
        chk("wr_ready_drain", csr_wr_ready, 1'b1);
        wait_done(ctx, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0;
        csr_wr_valid = 1'b0; csr_wr_ctx = '0; csr_wr_addr = '0; csr_wr_data = '0;
        commit_valid = 1'b0; commit_ctx = '0;
        issue_valid  = 1'b0; issue_ctx  = '0;
        retire_valid = 1'b0; retire_ctx = '0;
        for (int i = 0; i < NUM_CTX; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        repeat (3) tick();
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_commit_done", commit_done, 1'b0);
        chk("rst_out_csrs", out_csrs, '0);
        chk("rst_commit_ready", commit_ready, 1'b1);
        chk("rst_wr_ready", csr_wr_ready, 1'b1);
        chk("rst_issue_ready", issue_ready, 1'b1);
        reset_n = 1'b1;
        tick();

        // Shadow write invisible until commit
        do_write(1, 0, 32'h1000);
        do_issue(1);
        chk("zbuf_pre_commit", out_csrs.zbuf_addr, 32'h0);
        do_retire(1);
        do_commit(1);
        do_issue(1);
        chk("zbuf_post_commit", out_csrs.zbuf_addr, 32'h1000);
        do_retire(1);

        // Out-of-map addresses and narrow-field truncation
        do_write(0, 20, 32'hFFFF_FFFF);
        do_write(0, 31, 32'hFFFF_FFFF);
        do_write(0, 4, 32'hFF);
        do_write(0, 3, 32'h800);
        do_write(0, 15, 32'hCAFE_BABE);
        do_write(0, 16, 32'hFFFF_FFF6);
        do_write(0, 13, 32'h5);
        do_commit(0);
        do_issue(0);
        chk("zfunc_trunc", out_csrs.zfunc, 3'b111);
        chk("logic_op_trunc", out_csrs.logic_op, 4'h6);
        chk("zbuf_untouched", out_csrs.zbuf_addr, 32'h0);
        do_retire(0);

        // Commit waits for drain; other contexts keep issuing
        repeat (3) do_issue(2);
        do_write(2, 2, 32'hABCD);
        start_commit(2);
        tick();
        chk("drain_hold", commit_ready, 1'b0);
        chk("drain_no_done", commit_done, 1'b0);
        do_write(2, 9, 32'h3);
        issue_valid = 1'b1;
        issue_ctx   = 2'd2;
        #1;
        chk("issue_blk_cctx", issue_ready, 1'b0);
        issue_valid = 1'b0;
        do_issue(0);
        repeat (3) do_retire(2);
        chk("done_after_drain_not_yet", commit_done, 1'b0);
        wait_done(2, 1);
        do_issue(2);
        chk("cbuf_ctx2", out_csrs.cbuf_addr, 32'hABCD);
        do_retire(2);
        do_retire(0);

        // Counter saturation and issue+retire cancellation
        repeat (63) do_issue(3);
        issue_valid = 1'b1;
        issue_ctx   = 2'd3;
        #1;
        chk("issue_full", issue_ready, 1'b0);
        issue_ctx = 2'd0;
        #1;
        chk("issue_other_ctx", issue_ready, 1'b1);
        issue_valid = 1'b0;
        do_retire(3);
        issue_ctx = 2'd3;
        #1;
        chk("ready_at_62", issue_ready, 1'b1);
        issue_valid  = 1'b1;
        retire_valid = 1'b1;
        retire_ctx   = 2'd3;
        exp_q.push_back(m_active[3]);
        tick();
        issue_valid  = 1'b0;
        retire_valid = 1'b0;
        chk("out_valid_simul", out_valid, 1'b1);
        #1;
        chk("ready_still_62", issue_ready, 1'b1);
        do_issue(3);
        #1;
        chk("full_again", issue_ready, 1'b0);
        repeat (63) do_retire(3);
        do_retire(3);
        do_issue(3);
        start_commit(3);
        tick();
        chk("no_underflow_drain", commit_ready, 1'b0);
        do_retire(3);
        wait_done(3, 1);

        // Reset during DRAIN abandons the commit
        do_issue(1);
        do_write(1, 1, 32'h55);
        start_commit(1);
        chk("rst_drain_state", commit_ready, 1'b0);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < NUM_CTX; i++) begin
            m_shadow[i] = '0;
            m_active[i] = '0;
        end
        chk("rst2_commit_ready", commit_ready, 1'b1);
        chk("rst2_commit_done", commit_done, 1'b0);
        chk("rst2_out_valid", out_valid, 1'b0);
        chk("rst2_out_csrs", out_csrs, '0);
        do_commit(1);
        do_issue(1);
        chk("rst2_zbuf", out_csrs.zbuf_addr, 32'h0);
        chk("rst2_pitch", out_csrs.zbuf_pitch, 32'h0);
        do_retire(1);

        tick();
        tick();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_vx_rop_csr_bank
`default_nettype wire
